// File: rtl/rom_ctrl_pkg.sv
// Shared types for the rom_ctrl integrity-check sequencer: mubi encoding,
// sparse FSM state encoding and pwrmgr output defaults.
package rom_ctrl_pkg;

  typedef logic [3:0] mubi4_t;

  localparam mubi4_t MuBi4True  = 4'h6;
  localparam mubi4_t MuBi4False = 4'h9;

  localparam int unsigned NumDigestWords = 8;
  localparam int unsigned StateWidth     = 6;

  // Pairwise Hamming distance >= 3, and no state is all-zeros.
  typedef enum logic [StateWidth-1:0] {
    StIdle     = 6'b100110,
    StReadExp  = 6'b010101,
    StWaitRsp  = 6'b001011,
    StWaitKmac = 6'b110011,
    StCompare  = 6'b101101,
    StDone     = 6'b011110
  } check_state_e;

  localparam mubi4_t PwrmgrDoneDefault = MuBi4False;
  localparam mubi4_t PwrmgrGoodDefault = MuBi4False;

  function automatic mubi4_t mubi4_bool(input logic b);
    return b ? MuBi4True : MuBi4False;
  endfunction

endpackage

// File: rtl/prim_count.sv
// Redundant saturating up-counter: an up count and a mirrored down count whose
// sum must always equal MaxCnt; any disagreement flags err_o.
module prim_count #(
  parameter int unsigned Width  = 4,
  parameter int unsigned MaxCnt = (1 << Width) - 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             incr_en_i,
  output logic [Width-1:0] cnt_o,
  output logic             err_o
);

  logic [Width-1:0] up_q, dn_q;
  logic             step;

  assign step = incr_en_i && (up_q != Width'(MaxCnt));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      up_q <= '0;
      dn_q <= Width'(MaxCnt);
    end else if (step) begin
      up_q <= up_q + Width'(1);
      dn_q <= dn_q - Width'(1);
    end
  end

  assign cnt_o = up_q;
  assign err_o = (Width'(up_q + dn_q) != Width'(MaxCnt));

endmodule

// File: rtl/rom_ctrl_check_capture.sv
// Word-indexed capture of the expected digest read from ROM, with its
// receive counter and an overflow flag for responses beyond the last word.
module rom_ctrl_check_capture
  import rom_ctrl_pkg::*;
#(
  parameter  int unsigned NumWords = NumDigestWords,
  localparam int unsigned RcvW     = $clog2(NumWords + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rvalid_i,
  input  logic [31:0]              rdata_i,
  output logic [NumWords*32-1:0]   exp_digest_o,
  output logic [RcvW-1:0]          rcv_cnt_o,
  output logic                     overflow_c
);

  localparam int unsigned IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;

  logic [31:0]     words_q [NumWords];
  logic [RcvW-1:0] j_q;
  logic            wr_en;

  assign wr_en      = rvalid_i && (j_q < RcvW'(NumWords));
  assign overflow_c = rvalid_i && !wr_en;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      j_q <= '0;
      for (int unsigned w = 0; w < NumWords; w++) words_q[w] <= '0;
    end else if (wr_en) begin
      words_q[j_q[IdxW-1:0]] <= rdata_i;
      j_q                    <= j_q + RcvW'(1);
    end
  end

  always_comb begin
    exp_digest_o = '0;
    for (int unsigned w = 0; w < NumWords; w++) exp_digest_o[w*32 +: 32] = words_q[w];
  end

  assign rcv_cnt_o = j_q;

endmodule

// File: rtl/rom_ctrl_check_seq.sv
// One-shot ROM integrity-check sequencer: reads the expected digest, captures
// the KMAC digest, runs the comparator and reports to pwrmgr.
// Optional watchdog: define ROM_CTRL_CHECK_TIMEOUT_EN.
module rom_ctrl_check_seq
  import rom_ctrl_pkg::*;
#(
  parameter  int unsigned RomDepth      = 1024,
  parameter  int unsigned NumWords      = NumDigestWords,
  parameter  int unsigned TimeoutCycles = 4096,
  localparam int unsigned AddrW         = $clog2(RomDepth),
  localparam int unsigned DigestW       = NumWords * 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               rom_req_o,
  output logic [AddrW-1:0]   rom_addr_o,
  input  logic               rom_rvalid_i,
  input  logic [31:0]        rom_rdata_i,
  input  logic               kmac_valid_i,
  input  logic [DigestW-1:0] kmac_digest_i,
  output logic               cmp_start_o,
  input  logic               cmp_done_i,
  input  mubi4_t             cmp_good_i,
  output logic [DigestW-1:0] digest_o,
  output logic [DigestW-1:0] exp_digest_o,
  output mubi4_t             pwrmgr_done_o,
  output mubi4_t             pwrmgr_good_o,
  output logic               alert_o
);

  localparam int unsigned CntW = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned RcvW = $clog2(NumWords + 1);

  check_state_e      state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_next;
  logic              cnt_incr, cnt_err;
  logic [RcvW-1:0]   rcv_cnt;
  logic              rcv_ovf;
  logic              state_illegal, kmac_capture, timeout_c, alert_c;
  logic              rom_req_q, rd_pend_q, start_q, kmac_seen_q, alert_q;
  logic [AddrW-1:0]  rom_addr_q;
  logic [DigestW-1:0] digest_q;
  mubi4_t            done_q, good_q;

  prim_count #(
    .Width  (CntW),
    .MaxCnt (NumWords - 1)
  ) u_addr_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .incr_en_i (cnt_incr),
    .cnt_o     (cnt_q),
    .err_o     (cnt_err)
  );

  rom_ctrl_check_capture #(
    .NumWords (NumWords)
  ) u_capture (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rvalid_i     (rom_rvalid_i),
    .rdata_i      (rom_rdata_i),
    .exp_digest_o (exp_digest_o),
    .rcv_cnt_o    (rcv_cnt),
    .overflow_c   (rcv_ovf)
  );

  assign kmac_capture = kmac_valid_i && !kmac_seen_q &&
                        (state_q inside {StReadExp, StWaitRsp, StWaitKmac});

  always_comb begin
    state_d       = state_q;
    cnt_incr      = 1'b0;
    state_illegal = 1'b0;
    case (state_q)
      StIdle:     state_d = StReadExp;
      StReadExp: begin
        if (cnt_q == CntW'(NumWords - 1)) state_d  = StWaitRsp;
        else                              cnt_incr = 1'b1;
      end
      StWaitRsp: begin
        // An early digest lets us skip WaitKmac entirely.
        if (rcv_cnt == RcvW'(NumWords)) begin
          state_d = (kmac_seen_q || kmac_valid_i) ? StCompare : StWaitKmac;
        end
      end
      StWaitKmac: if (kmac_valid_i) state_d = StCompare;
      StCompare:  if (cmp_done_i)   state_d = StDone;
      StDone:     state_d = StDone;
      default:    state_illegal = 1'b1;
    endcase
    if (timeout_c) state_d = StDone;
  end

  assign cnt_next = cnt_incr ? CntW'(cnt_q + CntW'(1)) : cnt_q;

  assign alert_c = state_illegal | cnt_err | rcv_ovf | timeout_c |
                   (rom_rvalid_i & ~rd_pend_q) |
                   (kmac_valid_i & kmac_seen_q) |
                   (cmp_done_i & ~(state_q inside {StCompare, StDone}));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      rom_req_q   <= 1'b0;
      rom_addr_q  <= '0;
      rd_pend_q   <= 1'b0;
      start_q     <= 1'b0;
      kmac_seen_q <= 1'b0;
      digest_q    <= '0;
      done_q      <= PwrmgrDoneDefault;
      good_q      <= PwrmgrGoodDefault;
      alert_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_req_q   <= (state_d == StReadExp);
      if (state_d == StReadExp) begin
        rom_addr_q <= AddrW'(RomDepth - NumWords) + AddrW'(cnt_next);
      end
      rd_pend_q   <= rom_req_q;
      start_q     <= (state_d == StCompare) && (state_q != StCompare);
      kmac_seen_q <= kmac_seen_q | kmac_capture;
      if (kmac_capture) digest_q <= kmac_digest_i;
      done_q      <= mubi4_bool(state_d == StDone);
      if (state_q == StCompare && state_d == StDone) begin
        good_q <= mubi4_bool(!timeout_c && (cmp_good_i == MuBi4True));
      end
      alert_q     <= alert_q | alert_c;
    end
  end

`ifdef ROM_CTRL_CHECK_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

  logic [TmoW-1:0] tmo_q;
  logic            tmo_run;

  assign tmo_run   = state_q inside {StWaitRsp, StWaitKmac, StCompare};
  assign timeout_c = tmo_run && (tmo_q >= TmoW'(TimeoutCycles - 1));

  // Saturating per-state watchdog; restarts on every state change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if (!tmo_run || (state_d != state_q)) begin
      tmo_q <= '0;
    end else if (tmo_q != TmoW'(TimeoutCycles)) begin
      tmo_q <= tmo_q + TmoW'(1);
    end
  end
`else
  // Keeps TimeoutCycles referenced in builds without the watchdog.
  assign timeout_c = 1'b0 & (TimeoutCycles != 0);
`endif

  assign rom_req_o     = rom_req_q;
  assign rom_addr_o    = rom_addr_q;
  assign cmp_start_o   = start_q;
  assign digest_o      = digest_q;
  assign pwrmgr_done_o = done_q;
  assign pwrmgr_good_o = good_q;
  assign alert_o       = alert_q;

endmodule

// File: tb/tb_rom_ctrl_check_seq.sv
// Directed bench for rom_ctrl_check_seq: nominal, mismatch, early KMAC,
// alert sources and (with ROM_CTRL_CHECK_TIMEOUT_EN) the watchdog.
module tb_rom_ctrl_check_seq;
  import rom_ctrl_pkg::*;

  localparam int unsigned NW    = 8;
  localparam int unsigned DW    = NW * 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned Base  = 1016;

  logic          clk, rst_n;
  logic          rom_req, rom_rv_m, spur_rv, rom_rvalid;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_rdata;
  logic          kmac_valid;
  logic [DW-1:0] kmac_digest;
  logic          cmp_start, cmp_done;
  mubi4_t        cmp_good, pm_done, pm_good;
  logic [DW-1:0] digest, exp_digest;
  logic          alert;

  int total = 0;
  int bad   = 0;
  int n_start = 0;
  int start_base;
  logic [DW-1:0] exp_rom, dig2, dig3;

  rom_ctrl_check_seq #(
    .RomDepth      (1024),
    .NumWords      (NW),
    .TimeoutCycles (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rom_req_o     (rom_req),
    .rom_addr_o    (rom_addr),
    .rom_rvalid_i  (rom_rvalid),
    .rom_rdata_i   (rom_rdata),
    .kmac_valid_i  (kmac_valid),
    .kmac_digest_i (kmac_digest),
    .cmp_start_o   (cmp_start),
    .cmp_done_i    (cmp_done),
    .cmp_good_i    (cmp_good),
    .digest_o      (digest),
    .exp_digest_o  (exp_digest),
    .pwrmgr_done_o (pm_done),
    .pwrmgr_good_o (pm_good),
    .alert_o       (alert)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: top words hold 0x1000_0000 + word index, answered one cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_rv_m  <= 1'b0;
      rom_rdata <= '0;
    end else begin
      rom_rv_m  <= rom_req;
      rom_rdata <= 32'h1000_0000 + 32'(rom_addr) - 32'(Base);
    end
  end
  assign rom_rvalid = rom_rv_m | spur_rv;

  always @(negedge clk) if (cmp_start) n_start++;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    spur_rv     = 1'b0;
    kmac_valid  = 1'b0;
    kmac_digest = '0;
    cmp_done    = 1'b0;
    cmp_good    = MuBi4False;
    step(2);
    rst_n      = 1'b1;
    start_base = n_start;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NW; i++) exp_rom[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    dig2 = {8{32'hA5A5_5A5A}};
    dig3 = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_DEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;

    // Nominal pass, digest delivered while waiting in WaitKmac
    do_reset();
    chk("rst_req", DW'(rom_req), DW'(0));
    chk("rst_addr", DW'(rom_addr), DW'(0));
    chk("rst_start", DW'(cmp_start), DW'(0));
    chk("rst_done", DW'(pm_done), DW'(MuBi4False));
    chk("rst_good", DW'(pm_good), DW'(MuBi4False));
    chk("rst_alert", DW'(alert), DW'(0));
    chk("rst_digest", digest, '0);
    chk("rst_exp", exp_digest, '0);
    step(1);
    chk("req_first", DW'(rom_req), DW'(1));
    chk("addr_first", DW'(rom_addr), DW'(1016));
    step(7);
    chk("req_last", DW'(rom_req), DW'(1));
    chk("addr_last", DW'(rom_addr), DW'(1023));
    step(1);
    chk("req_off", DW'(rom_req), DW'(0));
    step(1);
    chk("exp_digest", exp_digest, exp_rom);
    step(1);
    chk("no_start_wait", DW'(cmp_start), DW'(0));
    step(1);
    kmac_valid = 1'b1; kmac_digest = exp_rom;
    step(1);
    kmac_valid = 1'b0;
    chk("start_nom", DW'(cmp_start), DW'(1));
    step(1);
    chk("start_once", DW'(cmp_start), DW'(0));
    chk("digest_nom", digest, exp_rom);
    cmp_done = 1'b1; cmp_good = MuBi4True;
    step(1);
    chk("done_nom", DW'(pm_done), DW'(MuBi4True));
    chk("good_nom", DW'(pm_good), DW'(MuBi4True));
    step(3);
    chk("alert_nom", DW'(alert), DW'(0));
    chk("start_count", DW'(n_start - start_base), DW'(1));

    // Mismatch, with the digest arriving in the same cycle the last word lands
    do_reset();
    step(10);
    kmac_valid = 1'b1; kmac_digest = dig2;
    step(1);
    kmac_valid = 1'b0;
    chk("start_mis", DW'(cmp_start), DW'(1));
    step(1);
    cmp_done = 1'b1; cmp_good = MuBi4False;
    step(1);
    chk("done_mis", DW'(pm_done), DW'(MuBi4True));
    chk("good_mis", DW'(pm_good), DW'(MuBi4False));
    chk("alert_mis", DW'(alert), DW'(0));
    chk("digest_mis", digest, dig2);

    // Early KMAC at i=2, non-canonical verdict, then a second KMAC pulse
    do_reset();
    step(3);
    chk("addr_i2", DW'(rom_addr), DW'(1018));
    kmac_valid = 1'b1; kmac_digest = dig3;
    step(1);
    kmac_valid = 1'b0; kmac_digest = '0;
    step(1);
    chk("digest_early", digest, dig3);
    step(5);
    chk("no_start_j8", DW'(cmp_start), DW'(0));
    step(1);
    chk("start_early", DW'(cmp_start), DW'(1));
    chk("digest_stable", digest, dig3);
    cmp_done = 1'b1; cmp_good = 4'h5;
    step(1);
    chk("done_early", DW'(pm_done), DW'(MuBi4True));
    chk("good_invalid", DW'(pm_good), DW'(MuBi4False));
    chk("alert_early", DW'(alert), DW'(0));
    kmac_valid = 1'b1;
    step(1);
    kmac_valid = 1'b0;
    chk("alert_kmac2", DW'(alert), DW'(1));

    // Spurious rvalid while in Idle; alert must stick until reset
    do_reset();
    spur_rv = 1'b1;
    step(1);
    spur_rv = 1'b0;
    chk("alert_spur", DW'(alert), DW'(1));
    step(20);
    chk("alert_sticky", DW'(alert), DW'(1));

    // Comparator done outside Compare/Done
    do_reset();
    chk("alert_cleared", DW'(alert), DW'(0));
    step(2);
    cmp_done = 1'b1;
    step(1);
    cmp_done = 1'b0;
    chk("alert_cmpdone", DW'(alert), DW'(1));

    // Illegal FSM encoding
    do_reset();
    step(3);
    chk("alert_pre_force", DW'(alert), DW'(0));
    force dut.state_q = check_state_e'(StateWidth'(0));
    step(1);
    chk("alert_fsm", DW'(alert), DW'(1));
    release dut.state_q;

`ifdef ROM_CTRL_CHECK_TIMEOUT_EN
    // KMAC never arrives: watchdog fires after 16 cycles in WaitKmac
    do_reset();
    step(26);
    chk("tmo_alert_pre", DW'(alert), DW'(0));
    chk("tmo_done_pre", DW'(pm_done), DW'(MuBi4False));
    step(1);
    chk("tmo_alert", DW'(alert), DW'(1));
    chk("tmo_done", DW'(pm_done), DW'(MuBi4True));
    chk("tmo_good", DW'(pm_good), DW'(MuBi4False));
`endif

    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
